// File: rtl/calc_pkg.sv
// Shared definitions for the calculator carry path: default operand width,
// number of prefix levels, and the bundle that travels down the prefix pipeline.
package calc_pkg;

  localparam int CALC_WIDTH = 16;
  localparam int CALC_LOG2W = 4;

  // One pipeline stage worth of state. p_orig and cin ride along untouched
  // so the final sum can be formed; p_grp/g_grp are the group propagate and
  // generate terms being combined level by level.
  typedef struct packed {
    logic [CALC_WIDTH-1:0] p_orig;
    logic [CALC_WIDTH-1:0] p_grp;
    logic [CALC_WIDTH-1:0] g_grp;
    logic                  cin;
    logic                  valid;
  } stage_t;

  // Build the stage-0 bundle: carry-in is folded into bit 0's generate term,
  // which turns the whole network into a pure prefix problem.
  function automatic stage_t fold_cin(input logic [CALC_WIDTH-1:0] p,
                                      input logic [CALC_WIDTH-1:0] g,
                                      input logic                  cin,
                                      input logic                  valid);
    stage_t s;
    s.p_orig   = p;
    s.p_grp    = p;
    s.g_grp    = g;
    s.g_grp[0] = g[0] | (p[0] & cin);
    s.cin      = cin;
    s.valid    = valid;
    return s;
  endfunction

endpackage

// File: rtl/pg_prefix_adder_if.sv
// Valid/ready bus between the half-adder array, the prefix adder and its consumer.
// master = upstream producer plus downstream consumer; slave = the adder.
interface pg_prefix_adder_if
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_p;
  logic [WIDTH-1:0] in_g;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output flush, in_valid, in_p, in_g, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  flush, in_valid, in_p, in_g, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );

endinterface

// File: rtl/pg_prefix_level.sv
// One Kogge-Stone prefix level (combining span DIST) followed by its stage
// register. The register advances with the rest of the pipeline on adv and
// drops its valid bit on flush.
module pg_prefix_level
  import calc_pkg::*;
#(
  parameter int DIST = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   adv_i,
  input  logic   flush_i,
  input  stage_t stage_i,
  output stage_t stage_o
);

  stage_t lvl_d;
  stage_t lvl_q;

  // Combine each position with the group DIST places below it; positions
  // below DIST already hold their complete prefix and pass through.
  always_comb begin
    // NOTE: default the whole bundle first so every bit is assigned on every
    // path; otherwise the untouched low positions would infer latches.
    lvl_d = stage_i;
    for (int i = DIST; i < CALC_WIDTH; i++) begin
      lvl_d.g_grp[i] = stage_i.g_grp[i] | (stage_i.p_grp[i] & stage_i.g_grp[i-DIST]);
      lvl_d.p_grp[i] = stage_i.p_grp[i] & stage_i.p_grp[i-DIST];
    end
  end

  // Stage register: load on advance, flush kills the valid bit only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q <= '0;
    end else begin
      // NOTE: non-blocking so every stage samples its predecessor's old
      // value on the same edge; blocking here would let data race through.
      if (adv_i) lvl_q <= lvl_d;
      if (flush_i) lvl_q.valid <= 1'b0;
    end
  end

  assign stage_o = lvl_q;

endmodule

// File: rtl/pg_prefix_adder.sv
// Pipelined Kogge-Stone carry network. Takes half-adder propagate/generate
// vectors plus carry-in and produces sum, carry-out and signed overflow.
// Pipeline: S0 input register, LOG2W prefix-level registers, output register.
// The whole pipe advances together whenever the output slot is free or drained.
module pg_prefix_adder
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH,
  parameter int LOG2W = CALC_LOG2W
) (
  input logic              clk,
  input logic              rst_n,
  pg_prefix_adder_if.slave bus
);

  logic   adv;
  stage_t s0_d;
  stage_t s0_q;
  stage_t stage [0:LOG2W];
  stage_t fin;

  logic [WIDTH-1:0] carries;
  logic [WIDTH-1:0] out_sum_d;
  logic             out_cout_d;
  logic             out_ovf_d;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_sum_q;
  logic             out_cout_q;
  logic             out_ovf_q;

  // The pipe moves as a unit: advance whenever the output slot is empty or
  // being taken this cycle. Bubbles are not squeezed out.
  assign adv          = ~out_valid_q | bus.out_ready;
  assign bus.in_ready = adv;

  // Stage-0 bundle; a flush cycle never lets a new operation in.
  always_comb begin
    s0_d = fold_cin(bus.in_p, bus.in_g, bus.in_cin, bus.in_valid & ~bus.flush);
  end

  // S0 input register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: data registers are cleared as well as valid bits because the
      // outputs must read zero during reset; this is a small flop array,
      // not a memory, so the reset costs nothing structural.
      s0_q <= '0;
    end else begin
      if (adv) s0_q <= s0_d;
      if (bus.flush) s0_q.valid <= 1'b0;
    end
  end

  assign stage[0] = s0_q;

  // One registered prefix level per stage, span doubling each level.
  for (genvar k = 0; k < LOG2W; k++) begin : g_level
    pg_prefix_level #(
      .DIST(1 << k)
    ) u_level (
      .clk     (clk),
      .rst_n   (rst_n),
      .adv_i   (adv),
      .flush_i (bus.flush),
      .stage_i (stage[k]),
      .stage_o (stage[k+1])
    );
  end

  assign fin = stage[LOG2W];

  // Final group generates are the carries out of each bit; carry into bit i
  // is the generate of bit i-1, with cin entering bit 0.
  always_comb begin
    carries    = {fin.g_grp[WIDTH-2:0], fin.cin};
    out_sum_d  = fin.p_orig ^ carries;
    out_cout_d = fin.g_grp[WIDTH-1];
    out_ovf_d  = fin.g_grp[WIDTH-1] ^ fin.g_grp[WIDTH-2];
  end

  // Output register; holds steady while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      if (adv) begin
        out_valid_q <= fin.valid;
        out_sum_q   <= out_sum_d;
        out_cout_q  <= out_cout_d;
        out_ovf_q   <= out_ovf_d;
      end
      if (bus.flush) out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_cout  = out_cout_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_pg_prefix_adder.sv
// Scoreboard bench for pg_prefix_adder: stimulus pushes expected results,
// an independent monitor pops and compares on every output transfer.
module tb_pg_prefix_adder;
  import calc_pkg::*;

  localparam int W = CALC_WIDTH;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pg_prefix_adder_if #(.WIDTH(W)) bus ();

  pg_prefix_adder #(
    .WIDTH(W),
    .LOG2W(CALC_LOG2W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_out = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: a + b = p + 2g; overflow is carry into MSB xor carry out.
  function automatic exp_t model(input logic [W-1:0] p, input logic [W-1:0] g, input logic cin);
    logic [W+1:0] full;
    exp_t m;
    full   = {2'b00, p} + {1'b0, g, 1'b0} + {{(W+1){1'b0}}, cin};
    m.sum  = full[W-1:0];
    m.cout = full[W];
    m.ovf  = full[W] ^ (full[W-1] ^ p[W-1]);
    return m;
  endfunction

  // Monitor: compare every completed output transfer against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", {31'b0, bus.out_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_out++;
        check("out_sum",  {16'b0, bus.out_sum}, {16'b0, e.sum});
        check("out_cout", {31'b0, bus.out_cout}, {31'b0, e.cout});
        check("out_ovf",  {31'b0, bus.out_ovf},  {31'b0, e.ovf});
      end
    end
  end

  // Present one operation and hold it until accepted. Called and returns at
  // posedge+1; back-to-back calls keep in_valid high continuously.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic push, input exp_t e, output int tries);
    logic acc;
    bus.in_valid = 1'b1;
    bus.in_p     = a ^ b;
    bus.in_g     = a & b;
    bus.in_cin   = cin;
    tries = 0;
    acc   = 1'b0;
    while (!acc && tries < 50) begin
      tries++;
      @(negedge clk);
      acc = bus.in_ready && !bus.flush;
      if (acc && push) sb.push_back(e);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!acc) check("issue_accept", {31'b0, acc}, 32'd1);
  endtask

  task automatic issue_dir(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                           input logic [W-1:0] sum, input logic cout, input logic ovf);
    exp_t e;
    int   t;
    e.sum  = sum;
    e.cout = cout;
    e.ovf  = ovf;
    issue(a, b, cin, 1'b1, e, t);
  endtask

  task automatic issue_rnd(input logic push, output int tries);
    logic [W-1:0] a, b;
    logic         cin;
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom_range(0, 1));
    issue(a, b, cin, push, model(a ^ b, a & b, cin), tries);
  endtask

  // After a lone op was just accepted, count edges until out_valid appears.
  task automatic time_op(input string name);
    int lat;
    lat = 0;
    forever begin
      @(negedge clk);
      if (bus.out_valid || lat >= 20) break;
      @(posedge clk);
      #1;
      lat++;
    end
    check(name, 32'(lat), 32'd5);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int budget;
    bus.out_ready = 1'b1;
    budget = 0;
    while (sb.size() > 0 && budget < 100) begin
      @(posedge clk);
      budget++;
    end
    #1;
    check("drain_empty", 32'(sb.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic quiet_window(input string name);
    repeat (10) begin
      @(negedge clk);
      check(name, {31'b0, bus.out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_p      = '0;
    bus.in_g      = '0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_out_sum",   {16'b0, bus.out_sum},   32'd0);
    check("rst_out_cout",  {31'b0, bus.out_cout},  32'd0);
    check("rst_out_ovf",   {31'b0, bus.out_ovf},   32'd0);
    check("rst_in_ready",  {31'b0, bus.in_ready},  32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: basic carry propagation and latency
    issue_dir(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    time_op("latency_basic");
    drain();

    // 2, 3: unsigned wrap, signed overflow, carry-in ripple, back to back
    issue_dir(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    issue_dir(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    issue_dir(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    issue_dir(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    drain();

    // 4: streaming, in_ready must never drop
    for (int i = 0; i < 20; i++) begin
      issue_rnd(1'b1, t);
      check("stream_in_ready", 32'(t), 32'd1);
    end
    drain();

    // 5: backpressure, output frozen on op 1 and input stalled
    bus.out_ready = 1'b0;
    issue_dir(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) issue_rnd(1'b1, t);
    repeat (10) begin
      @(negedge clk);
      check("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
      check("bp_out_sum",   {16'b0, bus.out_sum},   32'h5555);
      check("bp_in_ready",  {31'b0, bus.in_ready},  32'd0);
      @(posedge clk);
      #1;
    end
    drain();
    check("outputs_seen", 32'(n_out), 32'd31);

    // 6a: flush with three in flight
    for (int i = 0; i < 3; i++) issue_rnd(1'b0, t);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    quiet_window("flush_no_out");
    issue_dir(16'h0F0F, 16'h0101, 1'b1, 16'h1011, 1'b0, 1'b0);
    time_op("latency_after_flush");
    drain();

    // 6b: asynchronous reset with three in flight
    for (int i = 0; i < 3; i++) issue_rnd(1'b0, t);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, bus.out_valid}, 32'd0);
    check("async_rst_sum",   {16'b0, bus.out_sum},   32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    quiet_window("reset_no_out");
    issue_dir(16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0);
    time_op("latency_after_reset");
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
